// File: rtl/serial_word_feeder.sv
// serial_word_feeder
//   Upstream stage of the serial "1100" sequence detector. Takes parallel
//   words over a valid/ready handshake and shifts them out one bit per clock
//   on x, with x_valid framing each real data bit. A one-deep holding
//   register lets the next word be captured while the current one shifts,
//   so back-to-back words stream with no idle cycle between them.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] leaves first; 0: din[0] leaves first
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   din        parallel word to serialise
//   din_valid  din is offered this cycle
//   din_ready  block accepts din this cycle (combinational)
//   x          serial data bit (from flops)
//   x_valid    x carries a real data bit (from flops)
//   last       x is the final bit of the current word (from flops)
//   busy       a word sits in the shifter or the holding register
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hold;
  logic             hold_full;

  logic accept;
  logic at_last;
  logic load;

  assign din_ready = !reset && !hold_full;
  assign accept    = din_valid && din_ready;
  assign at_last   = (state == SHIFT) && (cnt == CNT_LAST);
  // The shifter takes the held word whenever it is idle or finishing a word,
  // which is what closes the gap between consecutive words.
  assign load      = hold_full && ((state == IDLE) || at_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      hold      <= '0;
    end else begin
      if (accept) hold <= din;

      // An accept wins over a drain on the same edge: the register then
      // holds the newly captured word.
      if (accept)    hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;

      case (state)
        IDLE: begin
          if (load) begin
            sh    <= hold;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!at_last) begin
            sh  <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
          end else if (load) begin
            sh  <= hold;
            cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs are decoded purely from flops, so they change only on clk.
  assign x_valid = (state == SHIFT);
  assign x       = x_valid && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
  assign last    = at_last;
  assign busy    = x_valid || hold_full;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder. Two instances share one stimulus stream:
// one MSB-first, one LSB-first. The reference model schedules each accepted
// word with plain arithmetic: a word accepted on edge E starts shifting on
// edge L = max(E+1, previous L + W) and is shown for W cycles. A monitor
// process pops the schedule and checks both instances every cycle.
module tb_serial_word_feeder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic rdy_m, x_m, xv_m, last_m, busy_m;
  logic rdy_l, x_l, xv_l, last_l, busy_l;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .x(x_m), .x_valid(xv_m), .last(last_m), .busy(busy_m));

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .x(x_l), .x_valid(xv_l), .last(last_l), .busy(busy_l));

  always #5 clk = ~clk;

  typedef struct {
    int           e;
    int           l;
    logic [W-1:0] w;
  } entry_t;

  entry_t q[$];
  int     cyc = 0;       // number of rising edges so far
  int     last_start = -100;
  int     n_chk = 0;
  int     n_fail = 0;
  bit     mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs after edge n are sampled on the following falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic ev, el, bm, bl;
      int   i;
      ev = 1'b0; el = 1'b0; bm = 1'b0; bl = 1'b0;
      if (q.size() > 0 && q[0].l <= cyc) begin
        i  = cyc - q[0].l;
        ev = 1'b1;
        bm = q[0].w[W-1-i];
        bl = q[0].w[i];
        el = (i == W - 1);
      end
      chk("x_valid_msb", 32'(xv_m), 32'(ev));
      chk("x_valid_lsb", 32'(xv_l), 32'(ev));
      chk("x_msb", 32'(x_m), 32'(bm));
      chk("x_lsb", 32'(x_l), 32'(bl));
      chk("last_msb", 32'(last_m), 32'(el));
      chk("last_lsb", 32'(last_l), 32'(el));
      chk("busy_msb", 32'(busy_m), 32'(q.size() > 0));
      chk("busy_lsb", 32'(busy_l), 32'(q.size() > 0));
      if (el) void'(q.pop_front());
    end
  end

  // One clock of stimulus: drive after the monitor has sampled, check
  // din_ready against the model, record any transfer, then take the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, output bit acc);
    bit held, rdy;
    @(negedge clk);
    #2;
    reset = r; din_valid = v; din = d;
    #1;
    held = 1'b0;
    foreach (q[k]) if (q[k].l > cyc) held = 1'b1;
    rdy = !r && !held;
    if (mon_en) begin
      chk("din_ready_msb", 32'(rdy_m), 32'(rdy));
      chk("din_ready_lsb", 32'(rdy_l), 32'(rdy));
    end
    acc = v && rdy;
    if (r) begin
      q.delete();
      last_start = -100;
    end else if (acc) begin
      entry_t en;
      en.e = cyc + 1;
      en.l = (cyc + 2 > last_start + W) ? cyc + 2 : last_start + W;
      en.w = d;
      last_start = en.l;
      q.push_back(en);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, $urandom, a);
  endtask

  // Hold a word on din until it is taken; a bounded wait counts as a failure.
  task automatic offer(input logic [W-1:0] d);
    bit a;
    int tries;
    tries = 0;
    do begin
      step(1'b0, 1'b1, d, a);
      tries++;
    end while (!a && tries < 4 * W);
    n_chk++;
    if (!a) begin
      n_fail++;
      $display("FAIL offer_timeout word %0h not accepted within %0d cycles", d, 4 * W);
    end
  endtask

  initial begin
    bit a;
    step(1'b1, 1'b0, '0, a);
    step(1'b1, 1'b0, '0, a);
    mon_en = 1'b1;

    // single word, then idle
    offer(8'hCC);
    idle(12);
    // two words streamed back to back
    offer(8'hA5);
    offer(8'h3C);
    idle(20);
    // three words: third waits for the first word's last bit
    offer(8'h11);
    offer(8'h22);
    offer(8'h33);
    idle(30);
    // single low bit, checked LSB-first by the second instance
    offer(8'h01);
    idle(12);
    // reset in the middle of a word
    offer(8'hFF);
    idle(4);
    step(1'b1, 1'b0, '0, a);
    idle(3);

    // random traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      logic r, v;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 99) < 60);
      step(r, v, W'($urandom), a);
    end

    idle(40);
    chk("drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
